// File: rtl/gol_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | gol_pkg : shared types and defaults for the Game of Life frame capture |
// | Rev 1.0 : initial release                                              |
// +------------------------------------------------------------------------+
package gol_pkg;

  typedef enum logic [1:0] {
    CORE_INPUT  = 2'b00,
    CORE_UPDATE = 2'b01,
    CORE_OUTPUT = 2'b10
  } core_state_e;

  localparam int c_DEFAULT_N = 5;

  typedef enum logic [1:0] {
    CAP_IDLE    = 2'b00,
    CAP_CAPTURE = 2'b01,
    CAP_DONE    = 2'b10
  } cap_state_e;

endpackage
`default_nettype wire

// File: rtl/gol_row_scanner.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | gol_row_scanner : dwell-timed one-hot row scan of an n x n frame       |
// | Rev 1.0 : initial release                                              |
// +------------------------------------------------------------------------+
module gol_row_scanner
  import gol_pkg::*;
#(
  parameter int N_SIDE = c_DEFAULT_N,
  parameter int DWELL  = 1024
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [N_SIDE*N_SIDE-1:0]   i_frame,
  output logic [N_SIDE-1:0]          o_row_sel,
  output logic [N_SIDE-1:0]          o_col_out
);

  localparam int              c_CW       = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam int              c_RW       = (N_SIDE > 1) ? $clog2(N_SIDE) : 1;
  localparam logic [c_CW-1:0] c_CNT_LAST = c_CW'(DWELL - 1);
  localparam logic [c_RW-1:0] c_ROW_LAST = c_RW'(N_SIDE - 1);

  logic [c_CW-1:0]   r_cnt;
  logic [c_RW-1:0]   r_row;
  logic [N_SIDE-1:0] w_col;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_cnt <= '0;
      r_row <= '0;
    end else if (r_cnt == c_CNT_LAST) begin
      r_cnt <= '0;
      r_row <= (r_row == c_ROW_LAST) ? '0 : r_row + 1'b1;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Reads the live buffer, so a new commit shows up mid-dwell without restarting the scan.
  always_comb begin
    w_col = '0;
    for (int c = 0; c < N_SIDE; c++) begin
      w_col[c] = i_frame[int'(r_row) * N_SIDE + c];
    end
  end

  assign o_row_sel = N_SIDE'(1) << r_row;
  assign o_col_out = w_col;

endmodule
`default_nettype wire

// File: rtl/gol_frame_capture.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | gol_frame_capture : deserializes Life core OUTPUT episodes into frames, |
// | drives an LED row scan. Option macro: GOL_POPCOUNT_EN. Rev 1.0         |
// +------------------------------------------------------------------------+
module gol_frame_capture
  import gol_pkg::*;
#(
  parameter int n     = c_DEFAULT_N,
  parameter int DWELL = 1024,
  parameter int GEN_W = 8
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [1:0]                   state_in,
  input  logic                         cell_in,
  input  logic                         freeze,
  output logic [n-1:0]                 row_sel,
  output logic [n-1:0]                 col_out,
  output logic                         frame_valid,
  output logic [GEN_W-1:0]             generation,
  output logic                         busy
`ifdef GOL_POPCOUNT_EN
  ,
  output logic [$clog2(n*n+1)-1:0]     population,
  output logic                         extinct
`endif
);

  localparam int              c_N    = n * n;
  localparam int              c_IW   = (c_N > 1) ? $clog2(c_N) : 1;
  localparam logic [c_IW-1:0] c_LAST = c_IW'(c_N - 1);

  cap_state_e        r_state, w_next;
  logic [c_N-1:0]    r_shift, r_buf;
  logic [c_IW-1:0]   r_idx, w_bit;
  logic [GEN_W-1:0]  r_gen;
  logic              r_pend, r_fv;
  logic              w_out, w_sample, w_last;

  assign w_out = (state_in == CORE_OUTPUT);
  assign w_bit = (r_state == CAP_IDLE) ? '0 : r_idx;

  always_ff @(posedge clock) begin
    if (reset) r_state <= CAP_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    w_sample = 1'b0;
    w_last   = 1'b0;
    case (r_state)
      CAP_IDLE: if (w_out) begin
        w_sample = 1'b1;
        w_last   = (c_N == 1);
        w_next   = w_last ? CAP_DONE : CAP_CAPTURE;
      end
      CAP_CAPTURE: if (w_out) begin
        w_sample = 1'b1;
        w_last   = (r_idx == c_LAST);
        w_next   = w_last ? CAP_DONE : CAP_CAPTURE;
      end else begin
        w_next = CAP_IDLE;
      end
      CAP_DONE: if (!w_out) w_next = CAP_IDLE;
      default:  w_next = CAP_IDLE;
    endcase
  end

`ifdef GOL_POPCOUNT_EN
  localparam int c_PW = $clog2(c_N + 1);
  logic [c_PW-1:0] r_pop, w_pop;

  always_comb begin
    w_pop = '0;
    for (int i = 0; i < c_N; i++) w_pop = w_pop + c_PW'(r_shift[i]);
  end

  always_ff @(posedge clock) begin
    if (reset)                r_pop <= '0;
    else if (r_pend && !freeze) r_pop <= w_pop;
  end

  assign population = r_pop;
  assign extinct    = (r_pop == '0) && (r_gen != '0);
`endif

  // Commit lands one edge after the last bit; nothing samples in DONE, so r_shift is stable.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_shift <= '0;
      r_idx   <= '0;
      r_pend  <= 1'b0;
      r_buf   <= '0;
      r_gen   <= '0;
      r_fv    <= 1'b0;
    end else begin
      r_fv   <= 1'b0;
      r_pend <= w_sample && w_last;
      if (w_sample) begin
        r_shift[w_bit] <= cell_in;
        r_idx          <= w_bit + 1'b1;
      end
      if (r_pend && !freeze) begin
        r_buf <= r_shift;
        r_gen <= r_gen + 1'b1;
        r_fv  <= 1'b1;
      end
    end
  end

  gol_row_scanner #(
    .N_SIDE (n),
    .DWELL  (DWELL)
  ) u_scan (
    .clock     (clock),
    .reset     (reset),
    .i_frame   (r_buf),
    .o_row_sel (row_sel),
    .o_col_out (col_out)
  );

  assign frame_valid = r_fv;
  assign generation  = r_gen;
  assign busy        = (r_state == CAP_CAPTURE);

endmodule
`default_nettype wire

// File: tb/tb_gol_frame_capture.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_gol_frame_capture : directed self-checking bench, n=5 DWELL=4 GEN_W=2|
// | Rev 1.0 : initial release                                              |
// +------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_gol_frame_capture;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] state_in = 2'b00;
  logic       cell_in = 1'b0;
  logic       freeze = 1'b0;
  logic [4:0] row_sel, col_out;
  logic       frame_valid, busy;
  logic [1:0] generation;
`ifdef GOL_POPCOUNT_EN
  logic [4:0] population;
  logic       extinct;
`endif

  int nvec = 0;
  int nerr = 0;
  int pulses, first;

  localparam logic [24:0] c_HBLINK = 25'h00000E0;
  localparam logic [24:0] c_VBLINK = 25'h0001084;

  always #5 clock = ~clock;

  gol_frame_capture #(.n(5), .DWELL(4), .GEN_W(2)) dut (
    .clock       (clock),
    .reset       (reset),
    .state_in    (state_in),
    .cell_in     (cell_in),
    .freeze      (freeze),
    .row_sel     (row_sel),
    .col_out     (col_out),
    .frame_valid (frame_valid),
    .generation  (generation),
    .busy        (busy)
`ifdef GOL_POPCOUNT_EN
    ,
    .population  (population),
    .extinct     (extinct)
`endif
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic stream(input logic [24:0] bits, input int len, output int np, output int fst);
    np  = 0;
    fst = 0;
    for (int i = 0; i < len; i++) begin
      state_in = 2'b10;
      cell_in  = (i < 25) ? bits[i] : 1'($urandom);
      step();
      if (i == 0) chk("busy_in_capture", 32'(busy), 32'd1);
      if (frame_valid) begin np++; if (fst == 0) fst = i + 1; end
    end
    state_in = 2'b01;
    cell_in  = 1'b0;
    for (int j = 0; j < 3; j++) begin
      step();
      if (frame_valid) begin np++; if (fst == 0) fst = len + j + 1; end
    end
  endtask

  task automatic row1(input string tag, input logic [4:0] exp);
    int k = 0;
    while (row_sel !== 5'b00010 && k < 30) begin step(); k++; end
    if (row_sel !== 5'b00010) chk({tag, "_row1_timeout"}, 32'(row_sel), 32'd2);
    else                      chk(tag, 32'(col_out), 32'(exp));
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_row_sel"},     32'(row_sel),     32'd1);
    chk({tag, "_col_out"},     32'(col_out),     32'd0);
    chk({tag, "_frame_valid"}, 32'(frame_valid), 32'd0);
    chk({tag, "_generation"},  32'(generation),  32'd0);
    chk({tag, "_busy"},        32'(busy),        32'd0);
`ifdef GOL_POPCOUNT_EN
    chk({tag, "_population"},  32'(population),  32'd0);
    chk({tag, "_extinct"},     32'(extinct),     32'd0);
`endif
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    step();
    step();
    chk_reset_state("reset");
    reset = 1'b0;

    // Idle scan: row advances every 4 edges after reset release
    for (int k = 1; k <= 100; k++) begin
      logic [4:0] e;
      step();
      e = 5'(1 << ((k / 4) % 5));
      chk("idle_row_sel", 32'(row_sel), 32'(e));
    end
    chk("idle_col_out", 32'(col_out), 32'd0);
    chk("idle_generation", 32'(generation), 32'd0);

    stream(c_HBLINK, 25, pulses, first);
    chk("hblink_pulses", 32'(pulses), 32'd1);
    chk("hblink_pulse_cycle", 32'(first), 32'd26);
    chk("hblink_generation", 32'(generation), 32'd1);
`ifdef GOL_POPCOUNT_EN
    chk("hblink_population", 32'(population), 32'd3);
    chk("hblink_extinct", 32'(extinct), 32'd0);
`endif
    row1("hblink_col_out", 5'b00111);

    stream(25'h1FFFFFF, 12, pulses, first);
    chk("partial_pulses", 32'(pulses), 32'd0);
    chk("partial_generation", 32'(generation), 32'd1);
    chk("partial_busy", 32'(busy), 32'd0);
    row1("partial_col_out", 5'b00111);

    state_in = 2'b11;
    cell_in  = 1'b1;
    pulses   = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (frame_valid) pulses++;
    end
    chk("state11_pulses", 32'(pulses), 32'd0);
    chk("state11_busy", 32'(busy), 32'd0);
    state_in = 2'b01;
    step();

    stream(c_VBLINK, 40, pulses, first);
    chk("long_pulses", 32'(pulses), 32'd1);
    chk("long_pulse_cycle", 32'(first), 32'd26);
    chk("long_generation", 32'(generation), 32'd2);
    row1("long_col_out", 5'b00100);

    freeze = 1'b1;
    stream(25'h1FFFFFF, 25, pulses, first);
    chk("freeze_pulses", 32'(pulses), 32'd0);
    chk("freeze_generation", 32'(generation), 32'd2);
    row1("freeze_col_out", 5'b00100);
    freeze = 1'b0;

    stream(25'h0, 25, pulses, first);
    chk("zero_pulses", 32'(pulses), 32'd1);
    chk("zero_generation", 32'(generation), 32'd3);
`ifdef GOL_POPCOUNT_EN
    chk("zero_population", 32'(population), 32'd0);
    chk("zero_extinct", 32'(extinct), 32'd1);
`endif
    row1("zero_col_out", 5'b00000);

    stream(c_HBLINK, 25, pulses, first);
    chk("wrap4_pulses", 32'(pulses), 32'd1);
    chk("wrap4_generation", 32'(generation), 32'd0);
`ifdef GOL_POPCOUNT_EN
    chk("wrap4_population", 32'(population), 32'd3);
`endif
    stream(c_HBLINK, 25, pulses, first);
    chk("wrap5_generation", 32'(generation), 32'd1);
    row1("wrap5_col_out", 5'b00111);

    // Reset landing while the 13th bit is on the wire
    for (int i = 0; i < 12; i++) begin
      state_in = 2'b10;
      cell_in  = 1'b1;
      step();
    end
    reset = 1'b1;
    step();
    chk_reset_state("midreset");
    reset    = 1'b0;
    state_in = 2'b01;
    step();
    chk("post_reset_busy", 32'(busy), 32'd0);

    stream(c_VBLINK, 25, pulses, first);
    chk("post_reset_pulses", 32'(pulses), 32'd1);
    chk("post_reset_pulse_cycle", 32'(first), 32'd26);
    chk("post_reset_generation", 32'(generation), 32'd1);
    row1("post_reset_col_out", 5'b00100);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
`default_nettype wire
